// File: rtl/counter_pkg.sv
// counter_pkg: shared constants and helpers for the counter family
package counter_pkg;
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT = 1;
  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;
  function automatic int cmp_width(input int w);
    return w + 1;
  endfunction
endpackage

// File: rtl/counter_bound_detect.sv
// counter_bound_detect: flags when a count sits at the top or bottom of its range
module counter_bound_detect #(
  parameter int WIDTH = 4,
  parameter longint MODULUS = 16
) (
  input  logic [WIDTH-1:0] q,
  output logic             at_max,
  output logic             at_min
);
  assign at_max = q == WIDTH'(MODULUS - 1);
  assign at_min = q == '0;
endmodule

// File: rtl/sync_updown_counter.sv
// sync_updown_counter: synchronous up/down modulus counter with load, wrap/saturate and flags
module sync_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter longint MODULUS = 16,
  parameter int MODE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             ovf,
  output logic             load_err
);
  localparam int CW = cmp_width(WIDTH);
  localparam logic [WIDTH-1:0] QMAX = WIDTH'(MODULUS - 1);
  localparam bit SAT = MODE == MODE_SAT;
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("sync_updown_counter: WIDTH out of range");
  end
  if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
    $error("sync_updown_counter: MODULUS out of range");
  end
  if (MODE != MODE_WRAP && MODE != MODE_SAT) begin : g_bad_mode
    $error("sync_updown_counter: MODE must be 0 or 1");
  end
  logic at_max, at_min, bnd, hit, din_ok;
  logic [WIDTH-1:0] q_step;
  counter_bound_detect #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_bound (
    .q(q),
    .at_max(at_max),
    .at_min(at_min)
  );
  assign bnd = up ? at_max : at_min;
  assign hit = en & bnd;
  assign din_ok = {1'b0, din} < CW'(MODULUS);
  assign tc = en & ~reset & ~clear & ~load & bnd;
  // next count for one enabled step, folding in wrap or saturate at the boundary
  always_comb begin
    q_step = up ? (at_max ? (SAT ? q : '0) : q + WIDTH'(1))
                : (at_min ? (SAT ? q : QMAX) : q - WIDTH'(1));
  end
  // priority: reset/clear, then load, then count; flags registered alongside q
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      q <= '0;
      wrap <= 1'b0;
      ovf <= 1'b0;
      load_err <= 1'b0;
    end else if (load) begin
      q <= din_ok ? din : q;
      wrap <= 1'b0;
      load_err <= ~din_ok;
    end else begin
      q <= en ? q_step : q;
      wrap <= hit;
      ovf <= ovf | hit;
      load_err <= 1'b0;
    end
  end
endmodule

// File: doc/sync_updown_counter.md
Name: sync_updown_counter

Overview:
- Parametrised, fully synchronous binary counter. It is the next-generation replacement for the team's 4-bit toggle ripple counter.
- Adds up/down direction, parallel load, programmable modulus, selectable wrap or saturate mode, terminal-count output and a sticky overflow flag.
- All state changes on the rising edge of a single clock. Usable as a prescaler, event counter or timer core.

Parameters:
- WIDTH, 4, counter width in bits; legal range 2..32.
- MODULUS, 16, count range is 0..MODULUS-1; legal range 2..2**WIDTH (elaboration error otherwise).
- MODE, 0, 0 = wrap at the boundary, 1 = saturate at the boundary.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  count enable; one step per clk when high.
- up  in  1  direction: 1 = increment, 0 = decrement; sampled each cycle.
- clear  in  1  synchronous clear of count and overflow flag.
- load  in  1  parallel load strobe.
- din  in  WIDTH  load value.
- q  out  WIDTH  registered count.
- tc  out  1  terminal count, combinational from registered state and inputs.
- wrap  out  1  registered one-cycle pulse on a boundary event.
- ovf  out  1  sticky flag: boundary event seen since the last reset or clear.
- load_err  out  1  registered one-cycle pulse when a load was rejected.

Behaviour:
- Reset: on a clk edge with reset=1, q=0, wrap=0, ovf=0, load_err=0. Reset overrides every other input.
- Priority per edge: reset > clear > load > en. Lower-priority actions are ignored in that cycle.
- clear=1: q=0, ovf=0, wrap=0, load_err=0.
- load=1 with din < MODULUS: q=din next cycle; wrap=0, load_err=0, ovf unchanged.
- load=1 with din >= MODULUS: q holds, load_err=1 for one cycle, ovf unchanged.
- en=1 and up=1:
  - q < MODULUS-1: q=q+1.
  - q == MODULUS-1, MODE=0: q=0, wrap=1, ovf=1.
  - q == MODULUS-1, MODE=1: q holds at MODULUS-1, wrap=1, ovf=1.
- en=1 and up=0:
  - q > 0: q=q-1.
  - q == 0, MODE=0: q=MODULUS-1, wrap=1, ovf=1.
  - q == 0, MODE=1: q holds at 0, wrap=1, ovf=1.
- en=0 (and no clear or load): q holds, wrap=0.
- Latency: q reflects the action one clk after the sampled inputs. wrap and load_err are valid in the same cycle as the updated q.
- tc = en & ~reset & ~clear & ~load & (up ? q==MODULUS-1 : q==0). It marks the cycle in which the boundary event will be taken. tc is usable for cascading: the next stage's en is driven from this stage's tc.
- Direction change mid-count: takes effect on the same edge. No pipeline and no hysteresis.
- Arithmetic is WIDTH bits with no carry out. q never leaves 0..MODULUS-1 under any input sequence, including reset deasserted mid-count or loads during counting.
- MODULUS == 2**WIDTH: the boundary compare reduces to all-ones, and natural WIDTH-bit overflow yields identical results.
- No internal clock gating. No asynchronous logic. No derived clocks.

Decomposition:
- Shared package counter_pkg:
  - MODE_WRAP=0, MODE_SAT=1 constants.
  - Legal-range bounds for WIDTH.
  - Helper function for the compare width.
- Sub-module counter_bound_detect: combinational; outputs at_max and at_min from q and MODULUS. Also reused by future timer blocks.
- Top level holds the priority mux, the q register and the flag registers.

Test Plan:
- Reset/up-wrap: WIDTH=4, MODULUS=10, MODE=0; reset 2 cycles, en=1, up=1 for 12 cycles → q=0..9,0,1. tc high when q=9. wrap pulses one cycle after q=9. ovf=1 thereafter.
- Down/saturate: MODE=1, MODULUS=16; load din=2, then en=1, up=0 for 5 cycles → q=2,1,0,0,0. wrap pulses on each edge taken at q=0. ovf=1.
- Load priority and range: MODULUS=10; load=1, en=1, din=7 → q=7, no count. Then load din=12 → q holds 7, load_err pulses 1 cycle, ovf unchanged.
- Clear vs count: q=5, ovf=1; assert clear=1 with en=1, load=1, din=3 → q=0, ovf=0, wrap=0. Next cycle en=1, up=1 → q=1.
- Sync reset mid-count: q=6, en=1; assert reset for one edge → q=0 and all flags 0 on that edge. Confirm no change before the edge, and that reset overrides a simultaneous load din=4.
- Cascade: two instances, WIDTH=4, MODULUS=16; stage-2 en driven from stage-1 tc. Run 40 cycles from reset → concatenated value counts 0..39. Stage-2 increments only on cycles where stage-1 goes 15→0.
